switch_bank_debounce: RTL
=========================

SWITCH_BANK_DEBOUNCE -- requirements
Module: switch_bank_debounce

Interface
REQ-001 SHALL have parameter: NUM_CH, 4, number of independent switch channels (1..32).
REQ-002 SHALL have parameter: DEBOUNCE_LIMIT, 250000, consecutive stable cycles before a level is accepted (>=2; 10 ms at 25 MHz).
REQ-003 SHALL have parameter: HOLD_LIMIT, 25000000, cycles of accepted-pressed before long-press (>DEBOUNCE_LIMIT; used only with SWITCH_BANK_LONG_PRESS_EN).
REQ-004 SHALL have port: i_clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port: i_sw  input  NUM_CH  raw asynchronous switch levels, 1 = pressed.
REQ-007 SHALL have port: i_toggle_mode  input  NUM_CH  per channel: 1 = o_led toggles on release, 0 = o_led follows o_sw.
REQ-008 SHALL have port: o_sw  output  NUM_CH  debounced level.
REQ-009 SHALL have port: o_press  output  NUM_CH  one-cycle pulse on accepted 0->1.
REQ-010 SHALL have port: o_release  output  NUM_CH  one-cycle pulse on accepted 1->0.
REQ-011 SHALL have port: o_led  output  NUM_CH  LED drive per REQ-019..021.
REQ-012 SHALL have port: o_long  output  NUM_CH  one-cycle long-press pulse (tied 0 without SWITCH_BANK_LONG_PRESS_EN).

Function
REQ-013 SHALL pass each i_sw bit through a 2-flop synchroniser before any other logic.
REQ-014 SHALL keep per channel a counter of width $clog2(DEBOUNCE_LIMIT); counter clears whenever synchronised input equals o_sw.
REQ-015 SHALL increment the counter each cycle synchronised input differs from o_sw; at count DEBOUNCE_LIMIT-1 with mismatch, o_sw inverts and counter clears on that edge.
REQ-016 SHALL give latency: a raw level held constant changes o_sw exactly DEBOUNCE_LIMIT+2 rising edges after the first edge sampling it.
REQ-017 SHALL reject any glitch shorter than DEBOUNCE_LIMIT synchronised cycles; o_sw unchanged, no pulses.
REQ-018 SHALL register o_press/o_release so they assert on the same edge o_sw changes, for exactly one cycle.
REQ-019 SHALL, when i_toggle_mode=0, drive o_led equal to o_sw (same cycle).
REQ-020 SHALL, when i_toggle_mode=1, invert o_led on the edge o_release asserts, otherwise hold.
REQ-021 SHALL, on i_toggle_mode 1->0, make o_led follow o_sw next cycle; on 0->1, hold the current o_led value.
REQ-022 SHALL treat channels fully independently; simultaneous events on several channels all take effect in the same cycle.

Reset
REQ-023 SHALL, while i_rst=1 at a rising edge, clear synchronisers, counters, hold counters, o_sw, o_press, o_release, o_led, o_long to 0.
REQ-024 SHALL, on reset mid-debounce, discard partial counts; a switch held pressed through reset is re-accepted DEBOUNCE_LIMIT+2 edges after i_rst falls, producing one o_press.

Configuration
REQ-025 SHALL, with SWITCH_BANK_LONG_PRESS_EN defined, count cycles with o_sw=1 per channel (saturating); at HOLD_LIMIT-1 pulse o_long once per press.
REQ-026 SHALL, with SWITCH_BANK_LONG_PRESS_EN defined, suppress the REQ-020 toggle on the release following an o_long pulse (o_release still pulses).
REQ-027 SHALL, without SWITCH_BANK_LONG_PRESS_EN, omit hold counters, tie o_long to 0, and toggle on every release.

Structure
REQ-028 SHALL place default parameter constants (DEBOUNCE_LIMIT, HOLD_LIMIT, NUM_CH) in shared package switch_bank_pkg.
REQ-029 SHALL implement one channel (synchroniser, debounce counter, edge pulses, LED, hold logic) as sub-module debounce_channel, generated NUM_CH times.

Verification (bench: NUM_CH=4, DEBOUNCE_LIMIT=4, HOLD_LIMIT=16)
REQ-030 SHALL check: ch0 raw 0->1 held 20 cycles -> o_sw[0]=1 exactly 6 edges later, o_press[0] one cycle same edge, other channels 0.
REQ-031 SHALL check: ch1 raw pulses of 3 cycles high/3 low repeated 5 times -> o_sw[1], o_press[1], o_led[1] stay 0.
REQ-032 SHALL check: ch2 toggle_mode=1, two clean press/release (8 cycles each) -> o_led[2] goes 1 at first o_release, 0 at second.
REQ-033 SHALL check: all 4 channels pressed same cycle -> all o_press bits assert on same edge; toggle_mode=0 -> o_led=4'b1111 on that edge.
REQ-034 SHALL check: i_rst asserted 2 cycles while ch3 pressed mid-count (count=2) -> outputs 0; o_press[3] exactly 6 edges after i_rst falls.
REQ-035 SHALL check (LONG_PRESS_EN): ch0 toggle_mode=1 held 30 cycles -> single o_long[0] pulse; release -> o_release[0] pulses, o_led[0] unchanged.

Source files
------------

// File: rtl/switch_bank_pkg.sv
// Shared defaults and types for the switch bank debouncer.
//   SB_NUM_CH          default channel count
//   SB_DEBOUNCE_LIMIT  default stable-cycle count before a level is accepted
//   SB_HOLD_LIMIT      default accepted-pressed cycles before a long press
//   ch_out_t           per-channel output bundle returned by debounce_channel
package switch_bank_pkg;

  localparam int SB_NUM_CH         = 4;
  localparam int SB_DEBOUNCE_LIMIT = 250000;   // 10 ms at 25 MHz
  localparam int SB_HOLD_LIMIT     = 25000000; // 1 s at 25 MHz

  typedef struct packed {
    logic sw;     // debounced level
    logic press;  // accepted 0->1 pulse
    logic rel;    // accepted 1->0 pulse
    logic led;    // LED drive
    logic lng;    // long-press pulse
  } ch_out_t;

endpackage

// File: rtl/switch_bank_debounce_channel.sv
// debounce_channel: one switch channel.
//   2-flop synchroniser -> mismatch counter -> debounced level with press /
//   release pulses, LED (follow or toggle-on-release), optional long press.
// Optional feature: define SWITCH_BANK_LONG_PRESS_EN to add the hold counter,
// the o_long pulse and suppression of the toggle on the release after it.
// Ports:
//   i_clk, i_rst    clock, synchronous active-high reset
//   i_sw            raw asynchronous switch level (1 = pressed)
//   i_toggle_mode   1 = LED toggles on release, 0 = LED follows level
//   o_q             ch_out_t bundle {sw, press, rel, led, lng}
module debounce_channel
  import switch_bank_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = SB_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = SB_HOLD_LIMIT
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_sw,
  input  logic    i_toggle_mode,
  output ch_out_t o_q
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT);

  if (DEBOUNCE_LIMIT < 2) begin : g_bad_limit
    $error("DEBOUNCE_LIMIT must be >= 2");
  end
  if (HOLD_LIMIT <= DEBOUNCE_LIMIT) begin : g_bad_hold
    $error("HOLD_LIMIT must exceed DEBOUNCE_LIMIT");
  end

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          sw_q, press_q, rel_q, led_q;
  logic          flip, rel_evt, toggle_ok, long_w;

  // The accepted level inverts on the cycle the counter has already seen
  // DEBOUNCE_LIMIT-1 mismatches and the mismatch still holds.
  assign flip    = (sync_q[1] != sw_q) && (cnt_q == CW'(DEBOUNCE_LIMIT - 1));
  assign rel_evt = flip & sw_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      sw_q    <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_sw};
      if (sync_q[1] == sw_q || flip) cnt_q <= '0;
      else                           cnt_q <= cnt_q + 1'b1;
      if (flip) sw_q <= ~sw_q;
      press_q <= flip & ~sw_q;
      rel_q   <= rel_evt;
      // Follow mode tracks the next level so LED and o_sw change together;
      // toggle mode holds whatever value it inherited.
      if (!i_toggle_mode)           led_q <= flip ? ~sw_q : sw_q;
      else if (rel_evt && toggle_ok) led_q <= ~led_q;
    end
  end

`ifdef SWITCH_BANK_LONG_PRESS_EN
  localparam int HW = $clog2(HOLD_LIMIT + 1);

  logic [HW-1:0] hold_q;
  logic          long_q, long_seen_q, long_hit;

  // Counts cycles the accepted level is 1; saturates at HOLD_LIMIT so the
  // pulse fires once per press.
  assign long_hit  = sw_q && (hold_q == HW'(HOLD_LIMIT - 1));
  assign toggle_ok = ~long_seen_q;
  assign long_w    = long_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_q      <= '0;
      long_q      <= 1'b0;
      long_seen_q <= 1'b0;
    end else begin
      long_q <= long_hit;
      if (!sw_q)                       hold_q <= '0;
      else if (hold_q != HW'(HOLD_LIMIT)) hold_q <= hold_q + 1'b1;
      if (rel_evt)       long_seen_q <= 1'b0;
      else if (long_hit) long_seen_q <= 1'b1;
    end
  end
`else
  assign toggle_ok = 1'b1;
  assign long_w    = 1'b0;
`endif

  assign o_q = '{sw: sw_q, press: press_q, rel: rel_q, led: led_q, lng: long_w};

endmodule

// File: rtl/switch_bank_debounce.sv
// switch_bank_debounce: NUM_CH independent debounced switch channels.
// Optional feature macro: SWITCH_BANK_LONG_PRESS_EN (long-press detection).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_sw             raw switch levels, 1 = pressed
//   i_toggle_mode    per channel LED mode (1 = toggle on release)
//   o_sw             debounced levels
//   o_press          one-cycle pulse on accepted 0->1
//   o_release        one-cycle pulse on accepted 1->0
//   o_led            LED drive
//   o_long           one-cycle long-press pulse (0 without the feature)
module switch_bank_debounce
  import switch_bank_pkg::*;
#(
  parameter int NUM_CH         = SB_NUM_CH,
  parameter int DEBOUNCE_LIMIT = SB_DEBOUNCE_LIMIT,
  parameter int HOLD_LIMIT     = SB_HOLD_LIMIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_sw,
  input  logic [NUM_CH-1:0] i_toggle_mode,
  output logic [NUM_CH-1:0] o_sw,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic [NUM_CH-1:0] o_led,
  output logic [NUM_CH-1:0] o_long
);

  if (NUM_CH < 1 || NUM_CH > 32) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..32");
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ch_out_t q;
    debounce_channel #(
      .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
      .HOLD_LIMIT     (HOLD_LIMIT)
    ) u_ch (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_sw          (i_sw[g]),
      .i_toggle_mode (i_toggle_mode[g]),
      .o_q           (q)
    );
    assign o_sw[g]      = q.sw;
    assign o_press[g]   = q.press;
    assign o_release[g] = q.rel;
    assign o_led[g]     = q.led;
    assign o_long[g]    = q.lng;
  end

endmodule
